dram_axi_writer: RTL and testbench

- AXI4 write master in the m_axi_aclk domain, directly downstream of the pixel-to-DRAM gearbox.
- Each dram_write_en pulse carries one 512-bit word from the first-word-fall-through CDC FIFO output; the block converts it into one single-beat AXI4 write.
- Drives dram_write_busy back to the gearbox for flow control.
- Reports sticky error flags and a completed-write counter for debug.

---
 rtl/dram_axi_pkg.sv | 19 +
 rtl/dram_axi_writer.sv | 203 ++++++++++++++++++++
 tb/tb_dram_axi_writer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_axi_pkg.sv
// Shared types and AXI constants for the DRAM write master.
package dram_axi_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

    // AWSIZE encoding for a full-width beat of data_width bits.
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/dram_axi_writer.sv
// Converts single-word gearbox write requests into single-beat AXI4 writes,
// with flow control back to the gearbox and sticky debug error flags.
module dram_axi_writer
    import dram_axi_pkg::*;
#(
    parameter int unsigned DRAM_ADDR_WIDTH = 39,
    parameter int unsigned DRAM_DATA_WIDTH = 512,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic                         m_axi_aclk,
    input  logic                         m_axi_aresetn,

    input  logic                         dram_write_en,
    input  logic [DRAM_ADDR_WIDTH-1:0]   dram_write_addr,
    input  logic [7:0]                   dram_write_len,
    input  logic [DRAM_DATA_WIDTH-1:0]   dram_write_data,
    output logic                         dram_write_busy,

    output logic [DRAM_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                   m_axi_awlen,
    output logic [2:0]                   m_axi_awsize,
    output logic [1:0]                   m_axi_awburst,
    output logic [3:0]                   m_axi_awcache,
    output logic [2:0]                   m_axi_awprot,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,

    output logic [DRAM_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DRAM_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                         m_axi_wlast,
    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,

    input  logic [1:0]                   m_axi_bresp,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,

    output logic [31:0]                  write_done_count,
    output logic                         err_bresp,
    output logic                         err_overrun,
    output logic                         err_unaligned,
    output logic                         err_len,
    output logic                         timeout_err
);

    localparam int unsigned STRB_W = DRAM_DATA_WIDTH / 8;
    localparam int unsigned OFS_W  = $clog2(STRB_W);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
    localparam logic [2:0]      AWSIZE = axi_size(DRAM_DATA_WIDTH);

    state_e                       r_state,         w_state_nxt;
    logic [DRAM_ADDR_WIDTH-1:0]   r_awaddr,        w_awaddr_nxt;
    logic [DRAM_DATA_WIDTH-1:0]   r_wdata,         w_wdata_nxt;
    logic                         r_awvalid,       w_awvalid_nxt;
    logic                         r_wvalid,        w_wvalid_nxt;
    logic                         r_bready,        w_bready_nxt;
    logic                         r_aw_done,       w_aw_done_nxt;
    logic                         r_w_done,        w_w_done_nxt;
    logic [TO_W-1:0]              r_to_cnt,        w_to_cnt_nxt;
    logic [31:0]                  r_done_cnt,      w_done_cnt_nxt;
    logic                         r_err_bresp,     w_err_bresp_nxt;
    logic                         r_err_overrun,   w_err_overrun_nxt;
    logic                         r_err_unaligned, w_err_unaligned_nxt;
    logic                         r_err_len,       w_err_len_nxt;
    logic                         r_timeout_err,   w_timeout_err_nxt;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;

    assign w_aw_hs = r_awvalid & m_axi_awready;
    assign w_w_hs  = r_wvalid  & m_axi_wready;
    assign w_b_hs  = m_axi_bvalid & r_bready;

    // Next-state and next-output logic for the write FSM and its counters.
    always_comb begin
        w_state_nxt         = r_state;
        w_awaddr_nxt        = r_awaddr;
        w_wdata_nxt         = r_wdata;
        w_awvalid_nxt       = r_awvalid;
        w_wvalid_nxt        = r_wvalid;
        w_bready_nxt        = r_bready;
        w_aw_done_nxt       = r_aw_done;
        w_w_done_nxt        = r_w_done;
        w_to_cnt_nxt        = r_to_cnt;
        w_done_cnt_nxt      = r_done_cnt;
        w_err_bresp_nxt     = r_err_bresp;
        w_err_overrun_nxt   = r_err_overrun;
        w_err_unaligned_nxt = r_err_unaligned;
        w_err_len_nxt       = r_err_len;
        w_timeout_err_nxt   = r_timeout_err;

        case (r_state)
            IDLE: begin
                if (dram_write_en) begin
                    w_awaddr_nxt  = {dram_write_addr[DRAM_ADDR_WIDTH-1:OFS_W], OFS_W'(0)};
                    w_wdata_nxt   = dram_write_data;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_to_cnt_nxt  = '0;
                    w_state_nxt   = ADDR_DATA;
                    if (dram_write_addr[OFS_W-1:0] != '0) w_err_unaligned_nxt = 1'b1;
                    if (dram_write_len != 8'd0)           w_err_len_nxt       = 1'b1;
                end
            end
            ADDR_DATA: begin
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = RESP;
                end
            end
            RESP: begin
                if (w_b_hs) begin
                    w_bready_nxt = 1'b0;
                    w_state_nxt  = IDLE;
                    if (m_axi_bresp == AXI_RESP_OKAY) w_done_cnt_nxt  = r_done_cnt + 32'd1;
                    else                              w_err_bresp_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Requests arriving mid-transaction are dropped; the transfer in flight continues.
        if (r_state != IDLE) begin
            if (dram_write_en) w_err_overrun_nxt = 1'b1;
            if (r_to_cnt != TO_MAX) w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
        if (w_to_cnt_nxt == TO_MAX) w_timeout_err_nxt = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            r_state         <= IDLE;
            r_awaddr        <= '0;
            r_wdata         <= '0;
            r_awvalid       <= 1'b0;
            r_wvalid        <= 1'b0;
            r_bready        <= 1'b0;
            r_aw_done       <= 1'b0;
            r_w_done        <= 1'b0;
            r_to_cnt        <= '0;
            r_done_cnt      <= '0;
            r_err_bresp     <= 1'b0;
            r_err_overrun   <= 1'b0;
            r_err_unaligned <= 1'b0;
            r_err_len       <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_awaddr        <= w_awaddr_nxt;
            r_wdata         <= w_wdata_nxt;
            r_awvalid       <= w_awvalid_nxt;
            r_wvalid        <= w_wvalid_nxt;
            r_bready        <= w_bready_nxt;
            r_aw_done       <= w_aw_done_nxt;
            r_w_done        <= w_w_done_nxt;
            r_to_cnt        <= w_to_cnt_nxt;
            r_done_cnt      <= w_done_cnt_nxt;
            r_err_bresp     <= w_err_bresp_nxt;
            r_err_overrun   <= w_err_overrun_nxt;
            r_err_unaligned <= w_err_unaligned_nxt;
            r_err_len       <= w_err_len_nxt;
            r_timeout_err   <= w_timeout_err_nxt;
        end
    end

    assign dram_write_busy  = (r_state != IDLE);

    assign m_axi_awaddr     = r_awaddr;
    assign m_axi_awlen      = 8'd0;
    assign m_axi_awsize     = AWSIZE;
    assign m_axi_awburst    = AXI_BURST_INCR;
    assign m_axi_awcache    = AXI_CACHE_DEFAULT;
    assign m_axi_awprot     = 3'b000;
    assign m_axi_awvalid    = r_awvalid;

    assign m_axi_wdata      = r_wdata;
    assign m_axi_wstrb      = '1;
    assign m_axi_wlast      = r_wvalid;
    assign m_axi_wvalid     = r_wvalid;

    assign m_axi_bready     = r_bready;

    assign write_done_count = r_done_cnt;
    assign err_bresp        = r_err_bresp;
    assign err_overrun      = r_err_overrun;
    assign err_unaligned    = r_err_unaligned;
    assign err_len          = r_err_len;
    assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_dram_axi_writer.sv
// Directed bench for dram_axi_writer with hand-computed expectations.
module tb_dram_axi_writer;

    localparam int unsigned AW = 39;
    localparam int unsigned DW = 512;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [AW-1:0]   addr;
    logic [7:0]      len;
    logic [DW-1:0]   data;
    logic            busy;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [31:0]     count;
    logic            e_bresp, e_over, e_unal, e_len, e_to;

    logic [DW-1:0]   d_a5;
    logic [DW-1:0]   d_5a;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned aw_hs  = 0;
    int unsigned w_hs   = 0;
    int unsigned busy_cyc = 0;

    always #5 clk = ~clk;

    dram_axi_writer dut (
        .m_axi_aclk       (clk),
        .m_axi_aresetn    (rst_n),
        .dram_write_en    (en),
        .dram_write_addr  (addr),
        .dram_write_len   (len),
        .dram_write_data  (data),
        .dram_write_busy  (busy),
        .m_axi_awaddr     (awaddr),
        .m_axi_awlen      (awlen),
        .m_axi_awsize     (awsize),
        .m_axi_awburst    (awburst),
        .m_axi_awcache    (awcache),
        .m_axi_awprot     (awprot),
        .m_axi_awvalid    (awvalid),
        .m_axi_awready    (awready),
        .m_axi_wdata      (wdata),
        .m_axi_wstrb      (wstrb),
        .m_axi_wlast      (wlast),
        .m_axi_wvalid     (wvalid),
        .m_axi_wready     (wready),
        .m_axi_bresp      (bresp),
        .m_axi_bvalid     (bvalid),
        .m_axi_bready     (bready),
        .write_done_count (count),
        .err_bresp        (e_bresp),
        .err_overrun      (e_over),
        .err_unaligned    (e_unal),
        .err_len          (e_len),
        .timeout_err      (e_to)
    );

    // Handshake and busy observers.
    always @(posedge clk) begin
        if (awvalid && awready) aw_hs <= aw_hs + 1;
        if (wvalid && wready)   w_hs  <= w_hs + 1;
        if (busy)               busy_cyc <= busy_cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [AW-1:0] a, input logic [7:0] l, input logic [DW-1:0] d);
        en = 1'b1; addr = a; len = l; data = d;
        tick();
        en = 1'b0;
    endtask

    // AW/W complete on the next edge, B is returned on the edge after.
    task automatic finish(input logic [1:0] resp);
        tick();
        bresp = resp; bvalid = 1'b1;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++;
        if ({busy, awvalid, wvalid, bready} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, awvalid, wvalid, bready});
        else passed++;
        total++;
        if ({count, e_bresp, e_over, e_unal, e_len, e_to} !== 37'd0)
            $display("FAIL reset_count_flags: got count=%0d flags=%b expected 0", count, {e_bresp, e_over, e_unal, e_len, e_to});
        else passed++;
        total++;
        if ({awaddr, wdata} !== '0)
            $display("FAIL reset_addr_data: got awaddr=%h expected 0", awaddr);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        int unsigned b0;
        awready = 1'b1; wready = 1'b1;
        b0 = busy_cyc;
        accept(39'h4_0000_0000, 8'd0, d_a5);
        total++;
        if ({awvalid, wvalid, wlast, busy} !== 4'b1111)
            $display("FAIL single_valids: got %b expected 1111", {awvalid, wvalid, wlast, busy});
        else passed++;
        total++;
        if (awaddr !== 39'h4_0000_0000)
            $display("FAIL single_awaddr: got %h expected 400000000", awaddr);
        else passed++;
        total++;
        if (wdata !== d_a5)
            $display("FAIL single_wdata: got %h expected %h", wdata, d_a5);
        else passed++;
        total++;
        if ({awlen, awsize, awburst, awcache, awprot} !== {8'd0, 3'd6, 2'b01, 4'b0011, 3'b000})
            $display("FAIL fixed_fields: got len=%h size=%h burst=%b cache=%b prot=%b expected 0/6/01/0011/000",
                     awlen, awsize, awburst, awcache, awprot);
        else passed++;
        total++;
        if (wstrb !== 64'hFFFF_FFFF_FFFF_FFFF)
            $display("FAIL wstrb: got %h expected all ones", wstrb);
        else passed++;
        tick();
        total++;
        if ({awvalid, wvalid, bready} !== 3'b001)
            $display("FAIL single_after_hs: got %b expected 001", {awvalid, wvalid, bready});
        else passed++;
        tick(); tick();
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        total++;
        if ({count, busy, bready} !== {32'd1, 1'b0, 1'b0})
            $display("FAIL single_complete: got count=%0d busy=%b bready=%b expected 1/0/0", count, busy, bready);
        else passed++;
        total++;
        if (busy_cyc - b0 !== 4)
            $display("FAIL single_busy_cycles: got %0d expected 4", busy_cyc - b0);
        else passed++;
    endtask

    task automatic test_backpressure();
        int unsigned w0;
        awready = 1'b0; wready = 1'b1;
        w0 = w_hs;
        accept(39'h4_0000_0080, 8'd0, d_5a);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({awvalid, wvalid, bready, awaddr} !== {1'b1, 1'b0, 1'b0, 39'h4_0000_0080})
                $display("FAIL bp_hold_%0d: got aw=%b w=%b b=%b addr=%h expected 1/0/0/400000080",
                         i, awvalid, wvalid, bready, awaddr);
            else passed++;
        end
        awready = 1'b1;
        tick();
        total++;
        if ({awvalid, bready} !== 2'b01)
            $display("FAIL bp_aw_done: got %b expected 01", {awvalid, bready});
        else passed++;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        total++;
        if ({count, busy} !== {32'd2, 1'b0})
            $display("FAIL bp_complete: got count=%0d busy=%b expected 2/0", count, busy);
        else passed++;
        total++;
        if (w_hs - w0 !== 1)
            $display("FAIL bp_w_handshakes: got %0d expected 1", w_hs - w0);
        else passed++;
    endtask

    task automatic test_overrun();
        int unsigned a0;
        awready = 1'b1; wready = 1'b1;
        a0 = aw_hs;
        total++;
        if ({e_bresp, e_over, e_unal, e_len, e_to} !== 5'b00000)
            $display("FAIL flags_clean: got %b expected 00000", {e_bresp, e_over, e_unal, e_len, e_to});
        else passed++;
        accept(39'h4_0000_0100, 8'd0, d_a5);
        accept(39'h4_0000_0140, 8'd0, d_5a);
        total++;
        if (e_over !== 1'b1)
            $display("FAIL overrun_flag: got %b expected 1", e_over);
        else passed++;
        total++;
        if ({awaddr, wdata} !== {39'h4_0000_0100, d_a5})
            $display("FAIL overrun_inflight: got awaddr=%h expected 400000100", awaddr);
        else passed++;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        total++;
        if ({count, busy} !== {32'd3, 1'b0})
            $display("FAIL overrun_complete: got count=%0d busy=%b expected 3/0", count, busy);
        else passed++;
        total++;
        if (aw_hs - a0 !== 1)
            $display("FAIL overrun_aw_handshakes: got %0d expected 1", aw_hs - a0);
        else passed++;
    endtask

    task automatic test_errors();
        accept(39'h4_0000_0200, 8'd0, d_a5);
        finish(2'b10);
        total++;
        if ({e_bresp, count} !== {1'b1, 32'd3})
            $display("FAIL bresp_err: got err=%b count=%0d expected 1/3", e_bresp, count);
        else passed++;
        accept(39'h4_0000_0010, 8'd0, d_5a);
        total++;
        if ({awaddr, e_unal} !== {39'h4_0000_0000, 1'b1})
            $display("FAIL unaligned: got awaddr=%h err=%b expected 400000000/1", awaddr, e_unal);
        else passed++;
        finish(2'b00);
        accept(39'h4_0000_0300, 8'd3, d_a5);
        total++;
        if ({awlen, e_len} !== {8'd0, 1'b1})
            $display("FAIL len_err: got awlen=%0d err=%b expected 0/1", awlen, e_len);
        else passed++;
        finish(2'b00);
        total++;
        if ({count, e_to} !== {32'd5, 1'b0})
            $display("FAIL errors_count: got count=%0d timeout=%b expected 5/0", count, e_to);
        else passed++;
    endtask

    task automatic test_timeout();
        accept(39'h4_0000_0400, 8'd0, d_5a);
        tick();
        repeat (4000) tick();
        total++;
        if ({e_to, busy} !== 2'b01)
            $display("FAIL timeout_early: got to=%b busy=%b expected 0/1", e_to, busy);
        else passed++;
        repeat (100) tick();
        total++;
        if ({e_to, busy, bready} !== 3'b111)
            $display("FAIL timeout_set: got to=%b busy=%b bready=%b expected 1/1/1", e_to, busy, bready);
        else passed++;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        total++;
        if ({busy, count, e_to} !== {1'b0, 32'd6, 1'b1})
            $display("FAIL timeout_recover: got busy=%b count=%0d to=%b expected 0/6/1", busy, count, e_to);
        else passed++;
    endtask

    task automatic test_reset_mid();
        awready = 1'b0; wready = 1'b0;
        accept(39'h4_0000_0440, 8'd0, d_a5);
        total++;
        if ({awvalid, wvalid, busy} !== 3'b111)
            $display("FAIL mid_pre: got %b expected 111", {awvalid, wvalid, busy});
        else passed++;
        rst_n = 1'b0;
        tick();
        total++;
        if ({awvalid, wvalid, bready, busy} !== 4'b0000)
            $display("FAIL mid_reset_ctrl: got %b expected 0000", {awvalid, wvalid, bready, busy});
        else passed++;
        total++;
        if ({count, e_bresp, e_over, e_unal, e_len, e_to} !== 37'd0)
            $display("FAIL mid_reset_flags: got count=%0d flags=%b expected 0", count, {e_bresp, e_over, e_unal, e_len, e_to});
        else passed++;
        total++;
        if ({awaddr, wdata} !== '0)
            $display("FAIL mid_reset_addr_data: got awaddr=%h expected 0", awaddr);
        else passed++;
        rst_n = 1'b1; awready = 1'b1; wready = 1'b1;
        tick();
        accept(39'h4_0000_0500, 8'd0, d_5a);
        total++;
        if ({awaddr, wdata} !== {39'h4_0000_0500, d_5a})
            $display("FAIL post_reset_write: got awaddr=%h expected 400000500", awaddr);
        else passed++;
        finish(2'b00);
        total++;
        if ({count, busy} !== {32'd1, 1'b0})
            $display("FAIL post_reset_count: got count=%0d busy=%b expected 1/0", count, busy);
        else passed++;
    endtask

    initial begin
        d_a5 = {64{8'hA5}};
        d_5a = {64{8'h5A}};
        rst_n = 1'b0; en = 1'b0; addr = '0; len = '0; data = '0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        test_reset();
        test_single_write();
        test_backpressure();
        test_overrun();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
